chunk_serial_adder: RTL and testbench

Multi-cycle, parametrised adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock. Carry ripples between chunks through a registered carry flop. It generalises the fixed 4-bit ripple adder to arbitrary width and adds subtract mode, signed-overflow detection and a start/busy/done handshake. It is intended for datapaths where a full-width combinational carry chain would not meet timing and area matters more than throughput.

---
 rtl/chunk_serial_adder.sv | 184 ++++++++++++++++++
 tb/tb_chunk_serial_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder
// Multi-cycle adder/subtractor: a WIDTH-bit operation is evaluated CHUNK bits
// per clock, with the inter-chunk carry held in a flop. This avoids a
// full-width combinational carry chain. Subtract is a + ~b + 1. A start/busy/
// done handshake frames each operation. Signed overflow is reported as the
// carry into the MSB XOR the carry out of the MSB.
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Number of chunk cycles and the counter that walks through them.
  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Control states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Reject configurations that cannot be split into whole chunks.
  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // The carry into a bit can be recovered from the sum bit and its two
  // addend bits: s = a ^ b ^ c  =>  c = s ^ a ^ b.
  function automatic logic carry_into_bit(input logic s_bit,
                                          input logic a_bit,
                                          input logic b_bit);
    return s_bit ^ a_bit ^ b_bit;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             accept_s;
  logic             last_s;

  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;       // b already inverted for subtract
  logic             carry_r;   // inter-chunk carry; holds c0 at accept
  logic [WIDTH-1:0] acc_r;

  int               bit_idx_s;
  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK:0]   chunk_add_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic             msb_cin_s;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  // Next-state logic; a new operation is accepted from IDLE or DONE only.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = (cnt_r == CNT_LAST);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Chunk datapath: add the current slice plus the carry flop, and merge the
  // slice result into a copy of the accumulator.
  always_comb begin
    bit_idx_s   = int'(cnt_r) * CHUNK;
    a_chunk_s   = a_r[bit_idx_s +: CHUNK];
    b_chunk_s   = b_r[bit_idx_s +: CHUNK];
    chunk_add_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
    acc_nxt_s   = acc_r;
    acc_nxt_s[bit_idx_s +: CHUNK] = chunk_add_s[CHUNK-1:0];
    // On the final chunk, bit CHUNK-1 of the slice is the operand MSB; for
    // CHUNK=1 this reduces to the carry flop itself.
    msb_cin_s   = carry_into_bit(chunk_add_s[CHUNK-1], a_chunk_s[CHUNK-1],
                                 b_chunk_s[CHUNK-1]);
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand capture on accept, then one chunk per cycle while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
    end else if (accept_s) begin
      a_r     <= a;
      b_r     <= sub ? ~b : b;
      carry_r <= sub ? 1'b1 : cin;
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
    end else if (state_r == ST_RUN) begin
      acc_r   <= acc_nxt_s;
      carry_r <= chunk_add_s[CHUNK];
      cnt_r   <= last_s ? CNT_ZERO : (cnt_r + CNT_W'(1));
    end else begin
      acc_r   <= acc_r;
      carry_r <= carry_r;
      cnt_r   <= cnt_r;
    end
  end

  // Result registers update only on the edge that finishes the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if ((state_r == ST_RUN) && last_s) begin
      sum_r  <= acc_nxt_s;
      cout_r <= chunk_add_s[CHUNK];
      ovf_r  <= msb_cin_s ^ chunk_add_s[CHUNK];
    end else begin
      sum_r  <= sum_r;
      cout_r <= cout_r;
      ovf_r  <= ovf_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Testbench for chunk_serial_adder. Four instances with (WIDTH, CHUNK) =
// (16,4), (16,16), (8,1) and (32,8) share the same stimulus (operands are
// truncated per instance). They are checked against an arithmetic reference.
module tb_chunk_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        cin;
  logic [31:0] a_in;
  logic [31:0] b_in;

  logic        busy_o [4];
  logic        done_o [4];
  logic        cout_o [4];
  logic        ovf_o  [4];
  logic [31:0] sum_o  [4];
  logic [15:0] s0;
  logic [15:0] s1;
  logic [7:0]  s2;
  logic [31:0] s3;

  int wid [4] = '{16, 16, 8, 32};
  int nch [4] = '{4, 1, 8, 4};

  int n_chk  = 0;
  int n_fail = 0;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a_in[15:0]), .b(b_in[15:0]),
    .cin(cin), .busy(busy_o[0]), .done(done_o[0]), .sum(s0), .cout(cout_o[0]), .ovf(ovf_o[0]));
  chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a_in[15:0]), .b(b_in[15:0]),
    .cin(cin), .busy(busy_o[1]), .done(done_o[1]), .sum(s1), .cout(cout_o[1]), .ovf(ovf_o[1]));
  chunk_serial_adder #(.WIDTH(8), .CHUNK(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin), .busy(busy_o[2]), .done(done_o[2]), .sum(s2), .cout(cout_o[2]), .ovf(ovf_o[2]));
  chunk_serial_adder #(.WIDTH(32), .CHUNK(8)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a_in), .b(b_in),
    .cin(cin), .busy(busy_o[3]), .done(done_o[3]), .sum(s3), .cout(cout_o[3]), .ovf(ovf_o[3]));

  assign sum_o[0] = {16'd0, s0};
  assign sum_o[1] = {16'd0, s1};
  assign sum_o[2] = {24'd0, s2};
  assign sum_o[3] = s3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain w-bit arithmetic. Returns {ovf, cout, sum[31:0]}.
  // Signed overflow: addends share a sign and the result sign differs.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] av,
                                         input logic [31:0] bv, input logic ci,
                                         input logic sb);
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bm;
    logic [63:0] full;
    logic [63:0] res;
    logic        co;
    logic        ov;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'd0, av} & mask;
    bm   = (sb ? ~{32'd0, bv} : {32'd0, bv}) & mask;
    full = am + bm + (sb ? 64'd1 : {63'd0, ci});
    res  = full & mask;
    co   = full[w];
    ov   = (am[w-1] == bm[w-1]) && (res[w-1] != am[w-1]);
    return {ov, co, res[31:0]};
  endfunction

  // Checks every instance's outputs against reset values.
  task automatic chk_reset_vals(input string tag);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("%s busy[%0d]", tag, j), busy_o[j], 1'b0);
      chk($sformatf("%s done[%0d]", tag, j), done_o[j], 1'b0);
      chk($sformatf("%s sum[%0d]", tag, j), sum_o[j], 32'd0);
      chk($sformatf("%s cout[%0d]", tag, j), cout_o[j], 1'b0);
      chk($sformatf("%s ovf[%0d]", tag, j), ovf_o[j], 1'b0);
    end
  endtask

  // One operation: pulse start, then check busy/done timing and the result on
  // every instance in mask. With use_k, instance 0 is also held to the given
  // constants. With disturb, start and operands are churned during RUN.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                       input logic sb, input logic [3:0] mask, input logic disturb,
                       input logic use_k, input logic [15:0] ks, input logic kc,
                       input logic ko, input string tag);
    logic [33:0] exp_r [4];
    @(negedge clk);
    a_in = av; b_in = bv; cin = ci; sub = sb; start = 1'b1;
    for (int j = 0; j < 4; j++) exp_r[j] = ref_op(wid[j], av, bv, ci, sb);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (disturb && i <= 2) begin
        start = 1'b1;
        a_in  = $urandom;
        b_in  = $urandom;
        sub   = 1'($urandom);
        cin   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      for (int j = 0; j < 4; j++) begin
        if (mask[j]) begin
          chk($sformatf("%s busy[%0d] c%0d", tag, j, i), busy_o[j], (i <= nch[j]));
          chk($sformatf("%s done[%0d] c%0d", tag, j, i), done_o[j], (i == nch[j] + 1));
          if (i == nch[j] + 1) begin
            chk($sformatf("%s sum[%0d]", tag, j), sum_o[j], exp_r[j][31:0]);
            chk($sformatf("%s cout[%0d]", tag, j), cout_o[j], exp_r[j][32]);
            chk($sformatf("%s ovf[%0d]", tag, j), ovf_o[j], exp_r[j][33]);
          end
        end
      end
      if (use_k && i == 5) begin
        chk({tag, " sum const"}, sum_o[0], {16'd0, ks});
        chk({tag, " cout const"}, cout_o[0], kc);
        chk({tag, " ovf const"}, ovf_o[0], ko);
      end
    end
  endtask

  logic [33:0] q [$];
  logic [33:0] e;

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a_in = 32'd0; b_in = 32'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("after_release");

    // Directed vectors (upper bits random to exercise the wide instance).
    do_op({16'($urandom), 16'h00FF}, {16'($urandom), 16'h0001}, 1'b0, 1'b0, 4'hF, 1'b0,
          1'b1, 16'h0100, 1'b0, 1'b0, "add_ff_1");
    do_op({16'($urandom), 16'hFFFF}, {16'($urandom), 16'h0001}, 1'b0, 1'b0, 4'hF, 1'b0,
          1'b1, 16'h0000, 1'b1, 1'b0, "add_wrap");
    do_op({16'($urandom), 16'h7FFF}, {16'($urandom), 16'h0000}, 1'b1, 1'b0, 4'hF, 1'b0,
          1'b1, 16'h8000, 1'b0, 1'b1, "add_cin_ovf");
    do_op({16'($urandom), 16'h0005}, {16'($urandom), 16'h0007}, 1'b0, 1'b1, 4'hF, 1'b0,
          1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
    do_op({16'($urandom), 16'h8000}, {16'($urandom), 16'h0001}, 1'b0, 1'b1, 4'hF, 1'b0,
          1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    do_op({16'($urandom), 16'h0005}, {16'($urandom), 16'h0007}, 1'b1, 1'b1, 4'hF, 1'b0,
          1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_cin_ignored");

    // Start and operands churned during RUN; the single-chunk instance would
    // legitimately accept from DONE, so it is excluded here.
    do_op($urandom, $urandom, 1'($urandom), 1'b0, 4'b1101, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0,
          "disturb_add");
    do_op($urandom, $urandom, 1'($urandom), 1'b1, 4'b1101, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0,
          "disturb_sub");

    // Start held high: instance 0 accepts every NCH+1 = 5 edges.
    q.delete();
    for (int k = 0; k < 20; k++) begin
      a_in = $urandom; b_in = $urandom; sub = 1'($urandom); cin = 1'($urandom); start = 1'b1;
      if (k % 5 == 0) q.push_back(ref_op(16, a_in, b_in, cin, sub));
      @(negedge clk);
      chk($sformatf("cont busy k%0d", k), busy_o[0], (k % 5 != 4));
      chk($sformatf("cont done k%0d", k), done_o[0], (k % 5 == 4));
      if (k % 5 == 4) begin
        e = q.pop_front();
        chk($sformatf("cont sum k%0d", k), sum_o[0], e[31:0]);
        chk($sformatf("cont cout k%0d", k), cout_o[0], e[32]);
        chk($sformatf("cont ovf k%0d", k), ovf_o[0], e[33]);
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset two cycles into an operation: outputs clear before any edge.
    do_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0,
          "pre_reset");
    @(negedge clk);
    a_in = $urandom; b_in = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("post_reset done[%0d] c%0d", j, i), done_o[j], 1'b0);
        chk($sformatf("post_reset busy[%0d] c%0d", j, i), busy_o[j], 1'b0);
      end
    end
    do_op($urandom, $urandom, 1'($urandom), 1'($urandom), 4'hF, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0,
          "after_reset_op");

    // Random sweep across all configurations.
    for (int n = 0; n < 30; n++) begin
      do_op($urandom, $urandom, 1'($urandom), 1'($urandom), 4'hF, 1'b0, 1'b0, 16'd0, 1'b0,
            1'b0, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
